// File: rtl/uart_bus_bridge.sv
// Memory-mapped bridge from the CPU data bus to a UART core: byte FIFOs both ways, status/control regs, TX handshake FSM.
// Bus reads return one cycle after bus_rd; a push into a full FIFO is dropped and latches a sticky overflow flag.

module uart_bridge_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 8,
   parameter int AW    = 3
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         push_vld,
   input  logic [W-1:0] push_dat,
   output logic         push_rdy,
   input  logic         pop_rdy,
   output logic         pop_vld,
   output logic [W-1:0] pop_dat,
   output logic         full
);
   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic          push_eff;
   logic          pop_eff;

   assign pop_vld  = (count != '0);
   assign full     = (count == (AW+1)'(DEPTH));
   assign pop_eff  = pop_rdy & pop_vld;
   // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
   assign push_rdy = ~full | pop_eff;
   assign push_eff = push_vld & push_rdy;
   assign pop_dat  = pop_vld ? mem[rd_ptr] : '0;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_eff) wr_ptr <= wr_ptr + 1'b1;
         if (pop_eff)  rd_ptr <= rd_ptr + 1'b1;
         case ({push_eff, pop_eff})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push_eff) mem[wr_ptr] <= push_dat;
   end
endmodule

module uart_bus_bridge #(
   parameter int WORD_LENGTH = 8,
   parameter int DATA_WIDTH  = 32,
   parameter int FIFO_DEPTH  = 8,
   parameter int ADDR_W      = 3
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [1:0]             bus_addr,
   input  logic                   bus_wr,
   input  logic                   bus_rd,
   input  logic [DATA_WIDTH-1:0]  bus_wdata,
   output logic [DATA_WIDTH-1:0]  bus_rdata,
   output logic                   irq,
   input  logic [WORD_LENGTH-1:0] uart_datarx,
   input  logic                   uart_rx_flag,
   input  logic                   uart_parity,
   input  logic                   uart_tx_busy,
   output logic                   uart_clear_rx,
   output logic [WORD_LENGTH-1:0] uart_datatx,
   output logic                   uart_transmit
);
   typedef enum logic [1:0] {TX_IDLE, TX_START, TX_WAIT_HI, TX_WAIT_LO} tx_state_t;

   typedef struct packed {
      logic tx_ovf;
      logic rx_ovf;
      logic par_err;
      logic tx_full;
      logic tx_empty;
      logic rx_full;
      logic rx_empty;
   } status_t;

   localparam logic [1:0] A_DATA   = 2'd0;
   localparam logic [1:0] A_STATUS = 2'd1;
   localparam logic [1:0] A_CTRL   = 2'd2;

   logic                   data_rd;
   logic                   data_wr;
   logic                   ctrl_wr;
   logic                   sticky_clr;
   logic                   rx_flag_q;
   logic                   rx_capture;
   logic                   rx_push_rdy;
   logic                   rx_vld;
   logic                   rx_full;
   logic [WORD_LENGTH-1:0] rx_head;
   logic                   tx_push_rdy;
   logic                   tx_vld;
   logic                   tx_full;
   logic [WORD_LENGTH-1:0] tx_head;
   logic                   tx_pop;
   logic                   tx_ovf;
   logic                   rx_ovf;
   logic                   par_err;
   logic                   rx_ie;
   status_t                status;
   logic [DATA_WIDTH-1:0]  rdata_nxt;
   tx_state_t              state;
   tx_state_t              state_nxt;
   logic                   unused_wdata;

   assign data_rd    = bus_rd & (bus_addr == A_DATA);
   assign data_wr    = bus_wr & (bus_addr == A_DATA);
   assign ctrl_wr    = bus_wr & (bus_addr == A_CTRL);
   assign sticky_clr = ctrl_wr & bus_wdata[1];
   assign unused_wdata = ^bus_wdata[DATA_WIDTH-1:WORD_LENGTH];

   // The UART holds its ready flag until cleared, so only the rising edge captures a byte.
   assign rx_capture    = uart_rx_flag & ~rx_flag_q;
   assign uart_clear_rx = rx_capture & reset;

   uart_bridge_fifo #(.W(WORD_LENGTH), .DEPTH(FIFO_DEPTH), .AW(ADDR_W)) u_rx_fifo (
      .clk      (clk),
      .reset    (reset),
      .push_vld (rx_capture),
      .push_dat (uart_datarx),
      .push_rdy (rx_push_rdy),
      .pop_rdy  (data_rd),
      .pop_vld  (rx_vld),
      .pop_dat  (rx_head),
      .full     (rx_full)
   );

   uart_bridge_fifo #(.W(WORD_LENGTH), .DEPTH(FIFO_DEPTH), .AW(ADDR_W)) u_tx_fifo (
      .clk      (clk),
      .reset    (reset),
      .push_vld (data_wr),
      .push_dat (bus_wdata[WORD_LENGTH-1:0]),
      .push_rdy (tx_push_rdy),
      .pop_rdy  (tx_pop),
      .pop_vld  (tx_vld),
      .pop_dat  (tx_head),
      .full     (tx_full)
   );

   // Sticky flags: a set arriving in the same cycle as a clear wins.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rx_flag_q <= 1'b0;
         tx_ovf    <= 1'b0;
         rx_ovf    <= 1'b0;
         par_err   <= 1'b0;
         rx_ie     <= 1'b0;
      end else begin
         rx_flag_q <= uart_rx_flag;
         tx_ovf    <= (tx_ovf  & ~sticky_clr) | (data_wr & ~tx_push_rdy);
         rx_ovf    <= (rx_ovf  & ~sticky_clr) | (rx_capture & ~rx_push_rdy);
         par_err   <= (par_err & ~sticky_clr) | (rx_capture & uart_parity);
         if (ctrl_wr) rx_ie <= bus_wdata[0];
      end
   end

   assign status = {tx_ovf, rx_ovf, par_err, tx_full, ~tx_vld, rx_full, ~rx_vld};
   assign irq    = rx_vld & rx_ie;

   always_comb begin
      rdata_nxt = '0;
      case (bus_addr)
         A_DATA:   rdata_nxt[WORD_LENGTH-1:0] = rx_head;
         A_STATUS: rdata_nxt[6:0] = status;
         A_CTRL:   rdata_nxt[0] = rx_ie;
         default:  ;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         bus_rdata <= '0;
      end else if (bus_rd) begin
         bus_rdata <= rdata_nxt;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= TX_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         TX_IDLE:    if (tx_vld && !uart_tx_busy) state_nxt = TX_START;
         TX_START:   state_nxt = TX_WAIT_HI;
         TX_WAIT_HI: if (uart_tx_busy)  state_nxt = TX_WAIT_LO;
         TX_WAIT_LO: if (!uart_tx_busy) state_nxt = TX_IDLE;
         default:    state_nxt = TX_IDLE;
      endcase
   end

   always_comb begin
      tx_pop        = 1'b0;
      uart_transmit = 1'b0;
      case (state)
         TX_IDLE:  tx_pop = tx_vld & ~uart_tx_busy;
         TX_START: uart_transmit = 1'b1;
         default:  ;
      endcase
   end

   // Byte is latched at the pop and held until the next pop, covering the whole busy window.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         uart_datatx <= '0;
      end else if (tx_pop) begin
         uart_datatx <= tx_head;
      end
   end
endmodule

// File: tb/tb_uart_bus_bridge.sv
// Bench for uart_bus_bridge: directed scenarios plus a randomized bus/RX mix against a queue-based model.
module tb_uart_bus_bridge;
   localparam int D = 8;

   logic        clk;
   logic        reset;
   logic [1:0]  bus_addr;
   logic        bus_wr;
   logic        bus_rd;
   logic [31:0] bus_wdata;
   logic [31:0] bus_rdata;
   logic        irq;
   logic [7:0]  uart_datarx;
   logic        uart_rx_flag;
   logic        uart_parity;
   logic        uart_tx_busy;
   logic        uart_clear_rx;
   logic [7:0]  uart_datatx;
   logic        uart_transmit;

   uart_bus_bridge #(.WORD_LENGTH(8), .DATA_WIDTH(32), .FIFO_DEPTH(D), .ADDR_W(3)) dut (
      .clk           (clk),
      .reset         (reset),
      .bus_addr      (bus_addr),
      .bus_wr        (bus_wr),
      .bus_rd        (bus_rd),
      .bus_wdata     (bus_wdata),
      .bus_rdata     (bus_rdata),
      .irq           (irq),
      .uart_datarx   (uart_datarx),
      .uart_rx_flag  (uart_rx_flag),
      .uart_parity   (uart_parity),
      .uart_tx_busy  (uart_tx_busy),
      .uart_clear_rx (uart_clear_rx),
      .uart_datatx   (uart_datatx),
      .uart_transmit (uart_transmit)
   );

   int tests = 0;
   int fails = 0;

   // Reference model state
   logic [7:0] rx_q[$];
   logic [7:0] tx_seen[$];
   logic [7:0] txb[$];
   bit         m_tx_ovf, m_rx_ovf, m_par, m_ie;
   int         m_tx_cnt;
   int         busy_len = 20;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] status_word();
      logic [31:0] s;
      s = '0;
      s[6] = m_tx_ovf;
      s[5] = m_rx_ovf;
      s[4] = m_par;
      s[3] = (m_tx_cnt == D);
      s[2] = (m_tx_cnt == 0);
      s[1] = (rx_q.size() == D);
      s[0] = (rx_q.size() == 0);
      return s;
   endfunction

   // UART transmitter model: logs each transmit pulse, then goes busy for busy_len cycles.
   initial begin
      uart_tx_busy = 1'b0;
      forever begin
         @(posedge clk);
         #2;
         if (reset && uart_transmit) begin
            tx_seen.push_back(uart_datatx);
            @(posedge clk);
            #2;
            check("tx_pulse_width", {31'b0, uart_transmit}, 32'd0);
            uart_tx_busy = 1'b1;
            repeat (busy_len) @(posedge clk);
            #2;
            uart_tx_busy = 1'b0;
         end
      end
   end

   // One bus cycle, optionally coincident with a UART RX flag rising edge.
   task automatic step(input bit rd, input bit wr, input logic [1:0] addr, input logic [31:0] wd,
                       input bit rx, input logic [7:0] rb, input bit par);
      logic [31:0] exp_rd;
      exp_rd = '0;
      if (rd) begin
         case (addr)
            2'd0: exp_rd = (rx_q.size() != 0) ? {24'b0, rx_q[0]} : 32'd0;
            2'd1: exp_rd = status_word();
            2'd2: exp_rd = {31'b0, m_ie};
            default: exp_rd = '0;
         endcase
      end
      bus_addr = addr; bus_rd = rd; bus_wr = wr; bus_wdata = wd;
      if (rx) begin
         uart_datarx = rb; uart_parity = par; uart_rx_flag = 1'b1;
      end
      #1;
      if (rx) check("clear_rx_pulse", {31'b0, uart_clear_rx}, 32'd1);
      if (rd && addr == 2'd0 && rx_q.size() != 0) void'(rx_q.pop_front());
      if (wr && addr == 2'd2) begin
         m_ie = wd[0];
         if (wd[1]) begin m_tx_ovf = 0; m_rx_ovf = 0; m_par = 0; end
      end
      if (rx) begin
         if (rx_q.size() < D) rx_q.push_back(rb);
         else m_rx_ovf = 1;
         if (par) m_par = 1;
      end
      tick();
      bus_rd = 1'b0; bus_wr = 1'b0;
      if (rd) check("rdata", bus_rdata, exp_rd);
      if (rx) begin
         check("clear_rx_one_cycle", {31'b0, uart_clear_rx}, 32'd0);
         uart_rx_flag = 1'b0; uart_parity = 1'b0;
         tick();
      end
      check("irq", {31'b0, irq}, {31'b0, (rx_q.size() != 0) && m_ie});
   endtask

   task automatic wait_tx(input int n, input int budget);
      int t = 0;
      while (tx_seen.size() < n && t < budget) begin
         tick();
         t++;
      end
      check("tx_count", tx_seen.size(), n);
   endtask

   initial begin
      int base;
      int t;
      int op;
      logic [7:0] b;

      reset = 1'b0; bus_addr = '0; bus_wr = 0; bus_rd = 0; bus_wdata = '0;
      uart_datarx = '0; uart_rx_flag = 0; uart_parity = 0;
      m_tx_ovf = 0; m_rx_ovf = 0; m_par = 0; m_ie = 0; m_tx_cnt = 0;
      #3;
      check("rst_rdata", bus_rdata, 32'd0);
      check("rst_irq", {31'b0, irq}, 32'd0);
      check("rst_transmit", {31'b0, uart_transmit}, 32'd0);
      check("rst_datatx", {24'b0, uart_datatx}, 32'd0);
      check("rst_clear_rx", {31'b0, uart_clear_rx}, 32'd0);
      tick(); tick();
      reset = 1'b1;
      tick();
      step(1, 0, 2'd1, 0, 0, 0, 0);
      step(1, 0, 2'd2, 0, 0, 0, 0);

      // Two bytes back to back through the TX path
      step(0, 1, 2'd0, 32'h41, 0, 0, 0);
      step(0, 1, 2'd0, 32'h42, 0, 0, 0);
      m_tx_cnt = 1;
      step(1, 0, 2'd1, 0, 0, 0, 0);
      wait_tx(2, 200);
      m_tx_cnt = 0;
      step(1, 0, 2'd1, 0, 0, 0, 0);
      check("tx0", {24'b0, tx_seen[0]}, 32'h41);
      check("tx1", {24'b0, tx_seen[1]}, 32'h42);
      repeat (30) tick();

      // Random TX bursts with random gaps
      tx_seen.delete(); txb.delete();
      for (int i = 0; i < int'($urandom_range(3, 5)); i++) begin
         b = 8'($urandom);
         txb.push_back(b);
         step(0, 1, 2'd0, {24'b0, b}, 0, 0, 0);
         repeat ($urandom_range(0, 3)) tick();
      end
      wait_tx(txb.size(), 1000);
      for (int i = 0; i < txb.size(); i++) check("tx_rand", {24'b0, tx_seen[i]}, {24'b0, txb[i]});
      repeat (30) tick();

      // TX overflow: first byte leaves for the UART, next D fill the FIFO, last is dropped
      tx_seen.delete(); txb.delete();
      for (int i = 0; i < D + 2; i++) begin
         b = 8'($urandom);
         txb.push_back(b);
         step(0, 1, 2'd0, {24'b0, b}, 0, 0, 0);
      end
      m_tx_ovf = 1; m_tx_cnt = D;
      step(1, 0, 2'd1, 0, 0, 0, 0);
      wait_tx(D + 1, 3000);
      repeat (40) tick();
      check("tx_no_extra", tx_seen.size(), D + 1);
      for (int i = 0; i < D + 1; i++) check("tx_ovf_seq", {24'b0, tx_seen[i]}, {24'b0, txb[i]});
      m_tx_cnt = 0;
      step(1, 0, 2'd1, 0, 0, 0, 0);
      step(0, 1, 2'd2, 32'h3, 0, 0, 0);
      step(1, 0, 2'd1, 0, 0, 0, 0);

      // Single RX byte with interrupt enabled
      step(0, 0, 2'd0, 0, 1, 8'h5A, 0);
      step(1, 0, 2'd1, 0, 0, 0, 0);
      step(1, 0, 2'd0, 0, 0, 0, 0);
      step(1, 0, 2'd1, 0, 0, 0, 0);

      // RX overflow: D+1 bytes with no reads, then drain past empty
      for (int i = 0; i < D + 1; i++) step(0, 0, 2'd0, 0, 1, 8'($urandom), 0);
      step(1, 0, 2'd1, 0, 0, 0, 0);
      for (int i = 0; i < D + 1; i++) step(1, 0, 2'd0, 0, 0, 0, 0);
      step(1, 0, 2'd1, 0, 0, 0, 0);

      // Full RX FIFO: read and capture in the same cycle must not overflow
      step(0, 1, 2'd2, 32'h3, 0, 0, 0);
      for (int i = 0; i < D; i++) step(0, 0, 2'd0, 0, 1, 8'($urandom), 0);
      step(1, 0, 2'd0, 0, 1, 8'hC3, 0);
      step(1, 0, 2'd1, 0, 0, 0, 0);
      for (int i = 0; i < D; i++) step(1, 0, 2'd0, 0, 0, 0, 0);

      // Empty RX FIFO: read and capture together returns 0 and leaves one entry
      step(1, 0, 2'd0, 0, 1, 8'h77, 0);
      step(1, 0, 2'd1, 0, 0, 0, 0);
      step(1, 0, 2'd0, 0, 0, 0, 0);

      // Parity error, clear, and clear coincident with a new error
      step(0, 0, 2'd0, 0, 1, 8'h11, 1);
      step(1, 0, 2'd1, 0, 0, 0, 0);
      step(0, 1, 2'd2, 32'h3, 0, 0, 0);
      step(1, 0, 2'd1, 0, 0, 0, 0);
      step(0, 1, 2'd2, 32'h3, 1, 8'h22, 1);
      step(1, 0, 2'd1, 0, 0, 0, 0);
      step(1, 0, 2'd0, 0, 0, 0, 0);
      step(1, 0, 2'd0, 0, 0, 0, 0);

      // Randomized RX / register traffic
      for (int i = 0; i < 80; i++) begin
         op = int'($urandom_range(0, 6));
         b  = 8'($urandom);
         case (op)
            0: step(0, 0, 2'd0, 0, 1, b, $urandom_range(0, 7) == 0);
            1: step(1, 0, 2'd0, 0, 0, 0, 0);
            2: step(1, 0, 2'd1, 0, 0, 0, 0);
            3: step(0, 1, 2'd2, {30'b0, $urandom_range(0, 3) == 0, 1'($urandom)}, 0, 0, 0);
            4: step(1, 0, 2'd0, 0, 1, b, 0);
            5: step(1, 0, 2'($urandom_range(2, 3)), 0, 0, 0, 0);
            default: step(0, 1, 2'd2, 32'h3, 1, b, 1);
         endcase
      end

      // Reset in the middle of a frame with bytes still queued
      step(0, 1, 2'd2, 32'h1, 1, 8'h99, 1);
      tx_seen.delete();
      for (int i = 0; i < 4; i++) step(0, 1, 2'd0, 32'hA0 + i, 0, 0, 0);
      t = 0;
      while (!uart_tx_busy && t < 200) begin tick(); t++; end
      check("busy_seen", {31'b0, uart_tx_busy}, 32'd1);
      repeat (3) tick();
      base = tx_seen.size();
      reset = 1'b0;
      #1;
      check("mid_rst_transmit", {31'b0, uart_transmit}, 32'd0);
      check("mid_rst_datatx", {24'b0, uart_datatx}, 32'd0);
      check("mid_rst_irq", {31'b0, irq}, 32'd0);
      check("mid_rst_rdata", bus_rdata, 32'd0);
      tick(); tick();
      reset = 1'b1;
      rx_q.delete(); m_tx_ovf = 0; m_rx_ovf = 0; m_par = 0; m_ie = 0; m_tx_cnt = 0;
      step(1, 0, 2'd1, 0, 0, 0, 0);
      step(1, 0, 2'd2, 0, 0, 0, 0);
      repeat (60) tick();
      check("no_tx_after_reset", tx_seen.size(), base);
      check("base_one_byte", base, 1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
